// File: rtl/axi4lite_regfile_slave.sv
// AXI4-Lite register file slave.
// DEPTH registers of DATA_WIDTH bits, addressed by word (byte offset bits ignored).
// Independent write FSM (WIDLE/WADDR/WDATA/WRESP) and read FSM (RIDLE/RDATA);
// one outstanding transaction per direction.
// Optional feature macro: AXI4LITE_SLVERR_EN -- when defined, word indices >= DEPTH
// get SLVERR (writes dropped, reads return 0); when undefined the index wraps
// modulo DEPTH and every response is OKAY.
//
// Handshake rule for every channel: a transfer happens on a rising edge where
// VALID and READY are both 1; a VALID source holds payload stable until then,
// and this slave holds B/R payload stable while B_VALID/R_VALID wait for READY.
module axi4lite_regfile_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                    A_CLK,
  input  logic                    A_RSTn,
  input  logic                    AW_VALID,
  output logic                    AW_READY,
  input  logic [ADDR_WIDTH-1:0]   AW_ADDR,
  input  logic                    W_VALID,
  output logic                    W_READY,
  input  logic [DATA_WIDTH-1:0]   W_DATA,
  input  logic [DATA_WIDTH/8-1:0] W_STRB,
  output logic                    B_VALID,
  input  logic                    B_READY,
  output logic [1:0]              B_RESP,
  input  logic                    AR_VALID,
  output logic                    AR_READY,
  input  logic [ADDR_WIDTH-1:0]   AR_ADDR,
  output logic                    R_VALID,
  input  logic                    R_READY,
  output logic [DATA_WIDTH-1:0]   R_DATA,
  output logic [1:0]              R_RESP,
  output logic [1:0]              wr_state,
  output logic                    rd_state
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam int DEPTH_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WIDLE, WADDR, WDATA, WRESP} wstate_t;
  typedef enum logic {RIDLE, RDATA} rstate_t;

  wstate_t w_state;
  rstate_t r_state;

  logic [DATA_WIDTH-1:0] regs [DEPTH];

  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;

  logic                  aw_hs, w_hs, ar_hs;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_data;
  logic [STRB_W-1:0]     c_strb;
  logic [DEPTH_W-1:0]    w_idx, r_idx;
  logic                  w_oob, r_oob;

  assign aw_hs = AW_VALID & AW_READY;
  assign w_hs  = W_VALID & W_READY;
  assign ar_hs = AR_VALID & AR_READY;

  assign wr_state = w_state;
  assign rd_state = r_state;

  // Pick the address/data/strobe that complete the write this cycle, if any.
  always_comb begin
    commit = 1'b0;
    c_addr = aw_addr_q;
    c_data = W_DATA;
    c_strb = W_STRB;
    unique case (w_state)
      WIDLE: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
          c_addr = AW_ADDR;
        end
      end
      WADDR: begin
        if (w_hs) commit = 1'b1;
      end
      WDATA: begin
        if (aw_hs) begin
          commit = 1'b1;
          c_addr = AW_ADDR;
          c_data = w_data_q;
          c_strb = w_strb_q;
        end
      end
      default: ;
    endcase
  end

  // Low index bits select the register; with wrapping, upper bits simply alias.
  assign w_idx = c_addr[ADDR_LSB +: DEPTH_W];
  assign r_idx = AR_ADDR[ADDR_LSB +: DEPTH_W];

`ifdef AXI4LITE_SLVERR_EN
  localparam logic [IDX_W:0] DEPTH_LIM = (IDX_W + 1)'(DEPTH);
  assign w_oob = ({1'b0, c_addr[ADDR_WIDTH-1:ADDR_LSB]} >= DEPTH_LIM);
  assign r_oob = ({1'b0, AR_ADDR[ADDR_WIDTH-1:ADDR_LSB]} >= DEPTH_LIM);
`else
  assign w_oob = 1'b0;
  assign r_oob = 1'b0;
`endif

  // Byte-offset bits (and aliased upper bits) carry no meaning for the register file.
  wire unused_addr_bits = ^{c_addr, AR_ADDR};

  // Register storage: byte-lane update on commit, suppressed for out-of-range words.
  always_ff @(posedge A_CLK or negedge A_RSTn) begin
    if (!A_RSTn) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (commit && !w_oob) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (c_strb[b]) regs[w_idx][8*b +: 8] <= c_data[8*b +: 8];
      end
    end
  end

  // Write FSM: collect AW and W in any order, commit, then hold B until accepted.
  always_ff @(posedge A_CLK or negedge A_RSTn) begin
    if (!A_RSTn) begin
      w_state   <= WIDLE;
      AW_READY  <= 1'b0;
      W_READY   <= 1'b0;
      B_VALID   <= 1'b0;
      B_RESP    <= RESP_OKAY;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (commit) begin
      w_state  <= WRESP;
      AW_READY <= 1'b0;
      W_READY  <= 1'b0;
      B_VALID  <= 1'b1;
      B_RESP   <= w_oob ? RESP_SLVERR : RESP_OKAY;
    end else begin
      unique case (w_state)
        WIDLE: begin
          if (aw_hs) begin
            aw_addr_q <= AW_ADDR;
            w_state   <= WADDR;
            AW_READY  <= 1'b0;
            W_READY   <= 1'b1;
          end else if (w_hs) begin
            w_data_q <= W_DATA;
            w_strb_q <= W_STRB;
            w_state  <= WDATA;
            AW_READY <= 1'b1;
            W_READY  <= 1'b0;
          end else begin
            // Also raises both readies on the first cycle after reset.
            AW_READY <= 1'b1;
            W_READY  <= 1'b1;
          end
        end
        WADDR: ;
        WDATA: ;
        WRESP: begin
          if (B_READY) begin
            w_state  <= WIDLE;
            B_VALID  <= 1'b0;
            AW_READY <= 1'b1;
            W_READY  <= 1'b1;
          end
        end
        default: w_state <= WIDLE;
      endcase
    end
  end

  // Read FSM: capture data at the AR handshake (pre-write value on collision), hold until R accepted.
  always_ff @(posedge A_CLK or negedge A_RSTn) begin
    if (!A_RSTn) begin
      r_state  <= RIDLE;
      AR_READY <= 1'b0;
      R_VALID  <= 1'b0;
      R_DATA   <= '0;
      R_RESP   <= RESP_OKAY;
    end else begin
      unique case (r_state)
        RIDLE: begin
          if (ar_hs) begin
            r_state  <= RDATA;
            AR_READY <= 1'b0;
            R_VALID  <= 1'b1;
            R_DATA   <= r_oob ? '0 : regs[r_idx];
            R_RESP   <= r_oob ? RESP_SLVERR : RESP_OKAY;
          end else begin
            AR_READY <= 1'b1;
          end
        end
        RDATA: begin
          if (R_READY) begin
            r_state  <= RIDLE;
            R_VALID  <= 1'b0;
            AR_READY <= 1'b1;
          end
        end
        default: r_state <= RIDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_regfile_slave.sv
// Directed bench for axi4lite_regfile_slave (DATA_WIDTH=32, ADDR_WIDTH=8, DEPTH=16).
// Inputs change and outputs are sampled on the falling edge.
module tb_axi4lite_regfile_slave;

  logic        A_CLK;
  logic        A_RSTn;
  logic        AW_VALID, AW_READY;
  logic [7:0]  AW_ADDR;
  logic        W_VALID, W_READY;
  logic [31:0] W_DATA;
  logic [3:0]  W_STRB;
  logic        B_VALID, B_READY;
  logic [1:0]  B_RESP;
  logic        AR_VALID, AR_READY;
  logic [7:0]  AR_ADDR;
  logic        R_VALID, R_READY;
  logic [31:0] R_DATA;
  logic [1:0]  R_RESP;
  logic [1:0]  wr_state;
  logic        rd_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  axi4lite_regfile_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(16)) dut (
    .A_CLK(A_CLK), .A_RSTn(A_RSTn),
    .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA), .W_STRB(W_STRB),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
    .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR),
    .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP),
    .wr_state(wr_state), .rd_state(rd_state)
  );

  // Clock and watchdog
  initial A_CLK = 1'b0;
  always #5 A_CLK = ~A_CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Present AW and W together; return at the falling edge after both were taken.
  task automatic issue_aw_w(input string tag, input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] s);
    int n;
    AW_ADDR = a; W_DATA = d; W_STRB = s;
    AW_VALID = 1'b1; W_VALID = 1'b1;
    n = 0;
    while (!(AW_READY && W_READY) && n < 20) begin
      @(negedge A_CLK);
      n++;
    end
    chk({tag, "_accept"}, 64'(n < 20), 64'd1);
    @(negedge A_CLK);
    AW_VALID = 1'b0; W_VALID = 1'b0;
  endtask

  // Wait (bounded) for B, check it, and let the handshake complete with B_READY=1.
  task automatic wait_b(input string tag, input logic [1:0] exp_resp);
    int n;
    B_READY = 1'b1;
    n = 0;
    while (!B_VALID && n < 20) begin
      @(negedge A_CLK);
      n++;
    end
    chk({tag, "_bvalid"}, 64'(B_VALID), 64'd1);
    chk({tag, "_bresp"}, 64'(B_RESP), 64'(exp_resp));
    @(negedge A_CLK);
    chk({tag, "_bdone"}, 64'(B_VALID), 64'd0);
  endtask

  task automatic wr(input string tag, input logic [7:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic [1:0] exp_resp);
    B_READY = 1'b1;
    issue_aw_w(tag, a, d, s);
    wait_b(tag, exp_resp);
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp_d,
                    input logic [1:0] exp_resp);
    int n;
    logic [31:0] e;
    exp_q.push_back(exp_d);
    AR_ADDR = a; AR_VALID = 1'b1; R_READY = 1'b1;
    n = 0;
    while (!AR_READY && n < 20) begin
      @(negedge A_CLK);
      n++;
    end
    chk({tag, "_araccept"}, 64'(n < 20), 64'd1);
    @(negedge A_CLK);
    AR_VALID = 1'b0;
    chk({tag, "_rvalid"}, 64'(R_VALID), 64'd1);
    e = exp_q.pop_front();
    chk({tag, "_rdata"}, 64'(R_DATA), 64'(e));
    chk({tag, "_rresp"}, 64'(R_RESP), 64'(exp_resp));
    @(negedge A_CLK);
    chk({tag, "_rdone"}, 64'(R_VALID), 64'd0);
  endtask

  initial begin
    logic [1:0]  oob_resp;
    logic [31:0] oob_rdata, alias0;
`ifdef AXI4LITE_SLVERR_EN
    oob_resp = 2'b10; oob_rdata = 32'h0; alias0 = 32'h0;
`else
    oob_resp = 2'b00; oob_rdata = 32'hCAFE_F00D; alias0 = 32'hCAFE_F00D;
`endif
    A_RSTn = 1'b0;
    AW_VALID = 1'b0; AW_ADDR = '0; W_VALID = 1'b0; W_DATA = '0; W_STRB = '0;
    B_READY = 1'b0; AR_VALID = 1'b0; AR_ADDR = '0; R_READY = 1'b0;

    // Reset state
    repeat (3) @(negedge A_CLK);
    chk("rst_aw_ready", 64'(AW_READY), 64'd0);
    chk("rst_w_ready", 64'(W_READY), 64'd0);
    chk("rst_ar_ready", 64'(AR_READY), 64'd0);
    chk("rst_b_valid", 64'(B_VALID), 64'd0);
    chk("rst_r_valid", 64'(R_VALID), 64'd0);
    chk("rst_r_data", 64'(R_DATA), 64'd0);
    A_RSTn = 1'b1;
    @(negedge A_CLK);
    chk("rel_aw_ready", 64'(AW_READY), 64'd1);
    chk("rel_w_ready", 64'(W_READY), 64'd1);
    chk("rel_ar_ready", 64'(AR_READY), 64'd1);

    // Basic same-cycle write then read
    B_READY = 1'b1;
    issue_aw_w("basic", 8'h04, 32'hDEAD_BEEF, 4'hF);
    chk("basic_b_next", 64'(B_VALID), 64'd1);
    chk("basic_wresp_aw_ready", 64'(AW_READY), 64'd0);
    chk("basic_wresp_w_ready", 64'(W_READY), 64'd0);
    wait_b("basic", 2'b00);
    rd("basic_rd", 8'h04, 32'hDEAD_BEEF, 2'b00);

    // W first with partial strobe, AW three cycles later
    B_READY = 1'b1;
    W_DATA = 32'h1122_3344; W_STRB = 4'h3; W_VALID = 1'b1;
    @(negedge A_CLK);
    W_VALID = 1'b0;
    chk("wfirst_w_ready", 64'(W_READY), 64'd0);
    chk("wfirst_state", 64'(wr_state), 64'd2);
    chk("wfirst_no_b", 64'(B_VALID), 64'd0);
    @(negedge A_CLK);
    @(negedge A_CLK);
    chk("wfirst_still_no_b", 64'(B_VALID), 64'd0);
    AW_ADDR = 8'h08; AW_VALID = 1'b1;
    @(negedge A_CLK);
    AW_VALID = 1'b0;
    chk("wfirst_b_after_aw", 64'(B_VALID), 64'd1);
    wait_b("wfirst", 2'b00);
    rd("wfirst_rd", 8'h08, 32'h0000_3344, 2'b00);

    // All-zero strobe is a no-op with OKAY
    wr("zstrb", 8'h08, 32'hFFFF_FFFF, 4'h0, 2'b00);
    rd("zstrb_rd", 8'h08, 32'h0000_3344, 2'b00);

    // B backpressure
    B_READY = 1'b0;
    issue_aw_w("bp", 8'h10, 32'hA5A5_5A5A, 4'hF);
    for (int i = 0; i < 5; i++) begin
      chk("bp_b_held", 64'(B_VALID), 64'd1);
      chk("bp_aw_ready_low", 64'(AW_READY), 64'd0);
      chk("bp_state", 64'(wr_state), 64'd3);
      @(negedge A_CLK);
    end
    B_READY = 1'b1;
    @(negedge A_CLK);
    chk("bp_b_released", 64'(B_VALID), 64'd0);
    chk("bp_aw_ready_back", 64'(AW_READY), 64'd1);

    // R backpressure
    R_READY = 1'b0; AR_ADDR = 8'h10; AR_VALID = 1'b1;
    @(negedge A_CLK);
    AR_VALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("rbp_r_held", 64'(R_VALID), 64'd1);
      chk("rbp_r_data", 64'(R_DATA), 64'hA5A5_5A5A);
      chk("rbp_ar_ready_low", 64'(AR_READY), 64'd0);
      @(negedge A_CLK);
    end
    R_READY = 1'b1;
    @(negedge A_CLK);
    chk("rbp_r_released", 64'(R_VALID), 64'd0);

    // Ignored byte offset bits
    rd("offset_rd", 8'h13, 32'hA5A5_5A5A, 2'b00);

    // Out-of-range word 16 (byte 0x40)
    wr("oob", 8'h40, 32'hCAFE_F00D, 4'hF, oob_resp);
    rd("oob_rd", 8'h40, oob_rdata, oob_resp);
    rd("oob_alias_rd", 8'h00, alias0, 2'b00);

    // Read accepted on the same edge as a write commit to the same word
    wr("col_pre", 8'h0C, 32'h1234_5678, 4'hF, 2'b00);
    B_READY = 1'b1; R_READY = 1'b0;
    AW_ADDR = 8'h0C; W_DATA = 32'h9ABC_DEF0; W_STRB = 4'hF;
    AW_VALID = 1'b1; W_VALID = 1'b1; AR_ADDR = 8'h0C; AR_VALID = 1'b1;
    @(negedge A_CLK);
    AW_VALID = 1'b0; W_VALID = 1'b0; AR_VALID = 1'b0;
    chk("col_r_valid", 64'(R_VALID), 64'd1);
    chk("col_old_data", 64'(R_DATA), 64'h1234_5678);
    chk("col_b_valid", 64'(B_VALID), 64'd1);
    R_READY = 1'b1;
    @(negedge A_CLK);
    chk("col_r_done", 64'(R_VALID), 64'd0);
    rd("col_new_rd", 8'h0C, 32'h9ABC_DEF0, 2'b00);

    // Reset asserted while the write response is pending
    B_READY = 1'b0;
    issue_aw_w("rstw", 8'h14, 32'h55AA_55AA, 4'hF);
    chk("rstw_in_wresp", 64'(B_VALID), 64'd1);
    A_RSTn = 1'b0;
    #1;
    chk("rstw_b_cleared", 64'(B_VALID), 64'd0);
    chk("rstw_aw_ready_low", 64'(AW_READY), 64'd0);
    chk("rstw_state_idle", 64'(wr_state), 64'd0);
    @(negedge A_CLK);
    @(negedge A_CLK);
    A_RSTn = 1'b1;
    @(negedge A_CLK);
    chk("rstw_aw_ready_up", 64'(AW_READY), 64'd1);
    chk("rstw_ar_ready_up", 64'(AR_READY), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("rstw_no_b", 64'(B_VALID), 64'd0);
      chk("rstw_no_r", 64'(R_VALID), 64'd0);
      @(negedge A_CLK);
    end
    rd("rstw_rd14", 8'h14, 32'h0, 2'b00);
    rd("rstw_rd04", 8'h04, 32'h0, 2'b00);
    rd("rstw_rd0c", 8'h0C, 32'h0, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi4lite_regfile_slave.md
AXI4LITE_REGFILE_SLAVE -- requirements
Module: axi4lite_regfile_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bus/register width (32 or 64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, byte-address width.
REQ-003 SHALL have parameter DEPTH, default 16, number of registers (power of 2, DEPTH*DATA_WIDTH/8 <= 2**ADDR_WIDTH).
REQ-004 SHALL have port A_CLK  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port A_RSTn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port AW_VALID  in  1  write address valid.
REQ-007 SHALL have port AW_READY  out  1  write address ready.
REQ-008 SHALL have port AW_ADDR  in  ADDR_WIDTH  write byte address.
REQ-009 SHALL have port W_VALID  in  1  write data valid.
REQ-010 SHALL have port W_READY  out  1  write data ready.
REQ-011 SHALL have port W_DATA  in  DATA_WIDTH  write data.
REQ-012 SHALL have port W_STRB  in  DATA_WIDTH/8  byte enables.
REQ-013 SHALL have port B_VALID  out  1  write response valid.
REQ-014 SHALL have port B_READY  in  1  write response ready.
REQ-015 SHALL have port B_RESP  out  2  write response (00 OKAY, 10 SLVERR).
REQ-016 SHALL have port AR_VALID  in  1  read address valid.
REQ-017 SHALL have port AR_READY  out  1  read address ready.
REQ-018 SHALL have port AR_ADDR  in  ADDR_WIDTH  read byte address.
REQ-019 SHALL have port R_VALID  out  1  read data valid.
REQ-020 SHALL have port R_READY  in  1  read data ready.
REQ-021 SHALL have port R_DATA  out  DATA_WIDTH  read data.
REQ-022 SHALL have port R_RESP  out  2  read response.

Function
REQ-023 SHALL index registers by word: idx = ADDR >> log2(DATA_WIDTH/8); low byte-offset bits ignored.
REQ-024 SHALL run the write FSM with states WIDLE, WADDR (AW held), WDATA (W held) and WRESP.
REQ-025 SHALL drive AW_READY=1 in WIDLE/WDATA and W_READY=1 in WIDLE/WADDR; both SHALL be 0 in WRESP.
REQ-026 SHALL accept AW and W in either order or in the same cycle, latching each on its handshake.
REQ-027 SHALL commit the write at the edge completing the second handshake, updating only bytes with W_STRB=1, then enter WRESP.
REQ-028 SHALL assert B_VALID the cycle after commit, hold it and B_RESP stable until B_READY=1, then return to WIDLE at that edge.
REQ-029 SHALL run the read FSM with states RIDLE (AR_READY=1) and RDATA (AR_READY=0, R_VALID=1).
REQ-030 SHALL register R_DATA/R_RESP at the AR handshake edge, so R_VALID rises the next cycle; R_DATA SHALL be held until the R_READY handshake, then return to RIDLE.
REQ-031 SHALL return pre-write data when a read is accepted on the same edge that commits a write to the same index.
REQ-032 SHALL run the read and write FSMs independently, with at most one outstanding transaction per direction.
REQ-033 SHALL commit an all-zero W_STRB write as a no-op with B_RESP=OKAY.

Reset
REQ-034 SHALL, on A_RSTn low, immediately clear all registers, B_VALID, R_VALID, R_DATA, B_RESP and R_RESP to 0, and force both FSMs to their idle states.
REQ-035 SHALL hold AW_READY, W_READY and AR_READY at 0 while A_RSTn=0, rising to 1 the first cycle after release.
REQ-036 SHALL discard any in-flight transaction when reset asserts mid-operation: no commit, and no B or R response after release.

Configuration
REQ-037 SHALL, with AXI4LITE_SLVERR_EN defined, answer any idx >= DEPTH with SLVERR (2'b10): writes not committed, reads return R_DATA=0.
REQ-038 SHALL, without AXI4LITE_SLVERR_EN, wrap idx modulo DEPTH and always return OKAY.

Verification (DATA_WIDTH=32, ADDR_WIDTH=8, DEPTH=16)
REQ-039 SHALL test a basic write then read: AW 0x04 + W 0xDEADBEEF, strb F, same cycle, B_READY=1 -> B_VALID next cycle, OKAY; read 0x04 -> R_DATA 0xDEADBEEF.
REQ-040 SHALL test AW/W ordering and strobes: W 0x11223344 strb 0x3, then AW 0x08 three cycles later -> B_VALID one cycle after AW handshake; read 0x08 -> 0x00003344.
REQ-041 SHALL test backpressure: B_READY=0 for 5 cycles -> B_VALID held, AW_READY=0 throughout; R_READY=0 for 5 cycles -> R_DATA stable.
REQ-042 SHALL test out-of-range access at AW/AR 0x40: SLVERR and R_DATA 0 with the macro; without it, OKAY and aliasing of register 0.
REQ-043 SHALL test collision and reset: read and write commit of 0x0C on the same edge -> old value returned; A_RSTn low during WRESP -> no B_VALID after release, reads return 0.
